// File: rtl/uart_rx_serial_if.sv
// ---------------------------------------------------------------------------
// uart_rx_serial_if
// Output word stream of the UART serial receiver: a one-entry valid/ready
// register carrying the received word and its per-word status flags.
//   rx_data     received word, meaningful while rx_valid=1
//   rx_valid    a word is held in the output register
//   rx_ready    consumer accepts the word when rx_valid & rx_ready at posedge clk
//   parity_err  parity mismatch for the held word
//   frame_err   stop bit sampled low for the held word
//   overrun     at least one frame dropped while the held word waited
// Modports: master = receiver (producer), slave = consumer.
// ---------------------------------------------------------------------------
interface uart_rx_serial_if #(
  parameter int DATA_BITS = 7
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_serial.sv
// ---------------------------------------------------------------------------
// uart_rx_serial
// Receives idle-high serial frames: start bit, DATA_BITS data bits LSB first,
// optional parity bit, one stop bit. The line is synchronised, each bit is
// sampled at mid-bit with a bit-period counter, and the finished word plus
// parity/frame status is committed to a one-entry valid/ready register.
// Ports:
//   clk   system clock (single domain)
//   rst   synchronous active-high reset
//   din   asynchronous serial line, idle = 1
//   rx    output word stream (uart_rx_serial_if.master)
//   busy  1 while a frame is being received (any state except IDLE/ARM)
// ---------------------------------------------------------------------------
module uart_rx_serial #(
  parameter int CLKS_PER_BIT = 1252,
  parameter int DATA_BITS    = 7,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  uart_rx_serial_if.master   rx,
  output logic               busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_ARM, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 perr_q, perr_n;
  logic                 ferr_q, ferr_n;
  logic                 commit_q, commit_n;
  logic                 din_s1, din_s;
  // Marks when the synchroniser holds real line samples instead of its
  // reset value, so ARM cannot be released by the reset-forced ones.
  logic [1:0]           fill;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_s1   <= 1'b1;
      din_s    <= 1'b1;
      fill     <= 2'b00;
      state    <= S_ARM;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      din_s1   <= din;
      din_s    <= din_s1;
      fill     <= {fill[0], 1'b1};
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shift    <= shift_n;
      perr_q   <= perr_n;
      ferr_q   <= ferr_n;
      commit_q <= commit_n;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift;
    perr_n   = perr_q;
    ferr_n   = ferr_q;
    commit_n = 1'b0;
    unique case (state)
      S_ARM: begin
        if (fill[1] && din_s) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (!din_s) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (din_s) begin
            state_n = S_IDLE;          // glitch: line back high at mid start bit
          end else begin
            state_n = S_DATA;
            idx_n   = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n        = '0;
          shift_n[idx] = din_s;
          if (idx == IDX_LAST) begin
            perr_n  = 1'b0;
            state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          perr_n  = (((^shift) ^ din_s) != (PARITY_ODD != 0));
          state_n = S_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n    = '0;
          commit_n = 1'b1;
          ferr_n   = ~din_s;
          // Leaving at mid stop bit lets a back-to-back start edge be seen.
          state_n  = din_s ? S_IDLE : S_BREAK;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_BREAK: begin
        if (din_s) state_n = S_IDLE;
      end
      default: state_n = S_ARM;
    endcase
  end

  assign busy = (state != S_ARM) && (state != S_IDLE);

  // Output register: a commit loads when the slot is free or is being
  // drained in the same cycle; otherwise the new frame is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx.rx_data    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.overrun    <= 1'b0;
    end else if (commit_q) begin
      if (!rx.rx_valid || rx.rx_ready) begin
        rx.rx_data    <= shift;
        rx.parity_err <= perr_q;
        rx.frame_err  <= ferr_q;
        rx.rx_valid   <= 1'b1;
        rx.overrun    <= 1'b0;
      end else begin
        rx.overrun    <= 1'b1;
      end
    end else if (rx.rx_valid && rx.rx_ready) begin
      rx.rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_serial.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_serial
// Drives serial frames into uart_rx_serial (short bit period) and checks the
// received words against a scoreboard of expected {data, parity_err,
// frame_err}, plus latency, overrun, break, glitch and mid-frame reset cases.
// ---------------------------------------------------------------------------
module tb_uart_rx_serial;

  localparam int CPB = 16;
  localparam int DB  = 7;
  localparam int PE  = 1;
  localparam int PO  = 1;
  localparam bit PODD_B = 1'b1;
  // Clocks from the first edge that sees the start bit to rx_valid rising.
  localparam int LAT = 2 + CPB / 2 + (DB + PE + 1) * CPB + 1;

  typedef struct packed {
    logic [DB-1:0] data;
    logic          perr;
    logic          ferr;
  } exp_t;

  typedef struct {
    logic [DB-1:0] data;
    logic          pflip;
    exp_t          exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic busy;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rise_cyc = -1;
  int   commit_cnt = 0;
  logic valid_prev = 1'b0;
  exp_t sb[$];

  uart_rx_serial_if #(.DATA_BITS(DB)) rx_if ();

  uart_rx_serial #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(PE), .PARITY_ODD(PO)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .rx(rx_if), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial frame; pflip inverts the correct parity bit.
  task automatic send_frame(input logic [DB-1:0] d, input logic pflip,
                            input logic stop_bit, input int stop_len, output int t0);
    t0  = cyc;
    din = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < DB; i++) begin
      din = d[i];
      repeat (CPB) tick();
    end
    if (PE != 0) begin
      din = ((^d) ^ PODD_B) ^ pflip;
      repeat (CPB) tick();
    end
    din = stop_bit;
    repeat (stop_len) tick();
    din = 1'b1;
  endtask

  // Scoreboard monitor, sampled mid-cycle: a handshake seen here completes
  // at the next posedge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rx_if.rx_valid && !valid_prev) begin
      rise_cyc = cyc;
      commit_cnt++;
    end
    valid_prev = rx_if.rx_valid;
    if (!rst && rx_if.rx_valid && rx_if.rx_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", 32'(rx_if.rx_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("sb_data", 32'(rx_if.rx_data), 32'(e.data));
        check("sb_parity_err", 32'(rx_if.parity_err), 32'(e.perr));
        check("sb_frame_err", 32'(rx_if.frame_err), 32'(e.ferr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   t0;
    int   t5;
    int   c0;

    vecs[0] = '{data: 7'h57, pflip: 1'b0, exp: '{data: 7'h57, perr: 1'b0, ferr: 1'b0}};
    vecs[1] = '{data: 7'h57, pflip: 1'b1, exp: '{data: 7'h57, perr: 1'b1, ferr: 1'b0}};
    vecs[2] = '{data: 7'h00, pflip: 1'b0, exp: '{data: 7'h00, perr: 1'b0, ferr: 1'b0}};
    vecs[3] = '{data: 7'h7F, pflip: 1'b0, exp: '{data: 7'h7F, perr: 1'b0, ferr: 1'b0}};
    vecs[4] = '{data: 7'h2A, pflip: 1'b1, exp: '{data: 7'h2A, perr: 1'b1, ferr: 1'b0}};
    vecs[5] = '{data: 7'h11, pflip: 1'b0, exp: '{data: 7'h11, perr: 1'b0, ferr: 1'b0}};

    rst = 1'b1;
    din = 1'b1;
    rx_if.rx_ready = 1'b0;
    repeat (4) tick();
    check("rst_rx_valid", 32'(rx_if.rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_if.rx_data), 32'd0);
    check("rst_parity_err", 32'(rx_if.parity_err), 32'd0);
    check("rst_frame_err", 32'(rx_if.frame_err), 32'd0);
    check("rst_overrun", 32'(rx_if.overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (8) tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Table-driven frames, consumer always ready.
    rx_if.rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rise_cyc = -1;
      sb.push_back(vecs[i].exp);
      send_frame(vecs[i].data, vecs[i].pflip, 1'b1, CPB, t0);
      repeat (4) tick();
      check($sformatf("latency_vec%0d", i), 32'(rise_cyc), 32'(t0 + 1 + LAT));
    end

    // Stop bit low, line held low for three bit times: one commit, frame_err.
    c0 = commit_cnt;
    sb.push_back('{data: 7'h2A, perr: 1'b0, ferr: 1'b1});
    send_frame(7'h2A, 1'b0, 1'b0, 3 * CPB, t0);
    check("break_busy", 32'(busy), 32'd1);
    repeat (6) tick();
    check("break_released", 32'(busy), 32'd0);
    check("break_one_commit", 32'(commit_cnt), 32'(c0 + 1));
    sb.push_back('{data: 7'h11, perr: 1'b0, ferr: 1'b0});
    send_frame(7'h11, 1'b0, 1'b1, CPB, t0);
    repeat (4) tick();
    check("after_break_commit", 32'(commit_cnt), 32'(c0 + 2));

    // Short low glitch on the idle line.
    c0 = commit_cnt;
    din = 1'b0;
    repeat (CPB / 4) tick();
    din = 1'b1;
    check("glitch_busy", 32'(busy), 32'd1);
    repeat (CPB) tick();
    check("glitch_idle", 32'(busy), 32'd0);
    repeat (2 * CPB) tick();
    check("glitch_no_commit", 32'(commit_cnt), 32'(c0));

    // Overrun: two frames without ready, then a third commits as the held
    // word is accepted in the same cycle.
    rx_if.rx_ready = 1'b0;
    sb.push_back('{data: 7'h01, perr: 1'b0, ferr: 1'b0});
    send_frame(7'h01, 1'b0, 1'b1, CPB, t0);
    repeat (4) tick();
    send_frame(7'h02, 1'b0, 1'b1, CPB, t0);
    repeat (4) tick();
    check("ovr_valid", 32'(rx_if.rx_valid), 32'd1);
    check("ovr_data_held", 32'(rx_if.rx_data), 32'h01);
    check("ovr_set", 32'(rx_if.overrun), 32'd1);
    sb.push_back('{data: 7'h03, perr: 1'b0, ferr: 1'b0});
    t5 = cyc;
    fork
      send_frame(7'h03, 1'b0, 1'b1, CPB, t0);
      begin
        while (cyc < t5 + LAT) tick();
        check("ovr_still_held", 32'(rx_if.rx_data), 32'h01);
        rx_if.rx_ready = 1'b1;
        tick();
        check("nobubble_valid", 32'(rx_if.rx_valid), 32'd1);
        check("nobubble_data", 32'(rx_if.rx_data), 32'h03);
        check("nobubble_overrun", 32'(rx_if.overrun), 32'd0);
      end
    join
    repeat (4) tick();
    check("drained_valid", 32'(rx_if.rx_valid), 32'd0);

    // Reset in the middle of data bit 3 with the line held low afterwards.
    c0  = commit_cnt;
    din = 1'b0;
    repeat (CPB) tick();
    din = 1'b1; repeat (CPB) tick();
    din = 1'b0; repeat (CPB) tick();
    din = 1'b1; repeat (CPB) tick();
    din = 1'b0; repeat (CPB / 2) tick();
    check("midframe_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(rx_if.rx_valid), 32'd0);
    repeat (12 * CPB) tick();
    check("arm_hold_busy", 32'(busy), 32'd0);
    check("arm_no_commit", 32'(commit_cnt), 32'(c0));
    din = 1'b1;
    repeat (6) tick();
    sb.push_back('{data: 7'h55, perr: 1'b0, ferr: 1'b0});
    rise_cyc = -1;
    send_frame(7'h55, 1'b0, 1'b1, CPB, t0);
    repeat (4) tick();
    check("post_rst_latency", 32'(rise_cyc), 32'(t0 + 1 + LAT));
    check("post_rst_commit", 32'(commit_cnt), 32'(c0 + 1));

    repeat (4) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
